// File: rtl/host_sequencer_pkg.sv
// Host sequencer shared types and defaults.
// State encoding and default sizing constants.
package host_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_REQ,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [7:0]  DEF_LOAD_BASE = 8'd0;
  localparam int          DEF_LOAD_LEN  = 8;
  localparam logic [7:0]  DEF_RES_BASE  = 8'd64;
  localparam int          DEF_RES_LEN   = 4;
  localparam logic [15:0] DEF_TIMEOUT   = 16'd5000;

endpackage

// File: rtl/host_sequencer_counter.sv
// 16-bit run-cycle counter.
// Synchronous clear, enable, saturates at all-ones.
module seq_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  // count up while enabled, hold at 16'hFFFF
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/host_sequencer.sv
// Host sequencer: preload data memory, run core, drain results.
// Owns the data-memory port outside RUN.
module host_sequencer
  import host_sequencer_pkg::*;
#(
  parameter logic [7:0]  LOAD_BASE = DEF_LOAD_BASE,
  parameter int          LOAD_LEN  = DEF_LOAD_LEN,
  parameter logic [7:0]  RES_BASE  = DEF_RES_BASE,
  parameter int          RES_LEN   = DEF_RES_LEN,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_dat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_dat,
  output logic        core_rst,
  output logic        req,
  input  logic        done,
  output logic        mem_sel,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_dat,
  input  logic [7:0]  mem_rd_dat,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] cycle_count
);

  localparam logic [8:0] LOAD_LAST = 9'(LOAD_LEN - 1);
  localparam logic [8:0] RES_LAST  = 9'(RES_LEN - 1);

  state_t     state;
  logic [8:0] idx;
  logic       cnt_clr;
  logic       cnt_en;
  logic       run_to;
  logic       in_load;
  logic       in_drain;

  assign in_load  = (state == S_LOAD);
  assign in_drain = (state == S_DRAIN);
  assign run_to   = (cycle_count == TIMEOUT);

  assign cnt_clr = (state == S_IDLE) && start;
  assign cnt_en  = (state == S_RUN) && !run_to;

  seq_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycle_count)
  );

  assign in_ready   = in_load;
  assign mem_sel    = in_load || in_drain;
  assign mem_wr_en  = in_load && in_valid;
  assign mem_wr_dat = in_dat;
  assign mem_addr   = in_load ? (LOAD_BASE + idx[7:0])
                              : (RES_BASE + idx[7:0]);
  assign out_valid  = in_drain;
  assign out_dat    = mem_rd_dat;
  assign core_rst   = reset || (state == S_CRST);
  assign req        = (state == S_REQ);
  assign busy       = (state != S_IDLE) && (state != S_FIN);

  // sequence state, byte index and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 9'd0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            idx         <= 9'd0;
            timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (idx == LOAD_LAST) begin
              state <= S_CRST;
              idx   <= 9'd0;
            end else begin
              idx <= idx + 9'd1;
            end
          end
        end
        S_CRST: begin
          // idx doubles as the two-cycle core reset timer
          if (idx == 9'd1) begin
            state <= S_REQ;
            idx   <= 9'd0;
          end else begin
            idx <= idx + 9'd1;
          end
        end
        S_REQ: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (done) begin
            state <= S_DRAIN;
            idx   <= 9'd0;
          end else if (run_to) begin
            timeout_err <= 1'b1;
            state       <= S_FIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == RES_LAST) begin
              state <= S_FIN;
              idx   <= 9'd0;
            end else begin
              idx <= idx + 9'd1;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_sequencer.sv
// Bench for host_sequencer: scoreboard of writes/results,
// core model with programmable done delay.
module tb_host_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dat;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_dat;
  logic        core_rst;
  logic        req;
  logic        done;
  logic        mem_sel;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_dat;
  logic [7:0]  mem_rd_dat;
  logic        busy;
  logic        timeout_err;
  logic [15:0] cycle_count;

  int checks = 0;
  int failures = 0;

  host_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dat      (in_dat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dat     (out_dat),
    .core_rst    (core_rst),
    .req         (req),
    .done        (done),
    .mem_sel     (mem_sel),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_dat  (mem_wr_dat),
    .mem_rd_dat  (mem_rd_dat),
    .busy        (busy),
    .timeout_err (timeout_err),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory contents as seen by the read port
  assign mem_rd_dat = mem_addr ^ 8'h5A;

  // core model: done rises done_delay cycles after req
  int done_delay = 0;
  bit active = 0;
  int since = 0;
  always @(posedge clk) begin
    if (core_rst) begin
      active <= 0;
    end else if (req) begin
      active <= 1;
      since <= 0;
    end else if (active && since < 100000) begin
      since <= since + 1;
    end
  end
  assign done = active && (done_delay > 0) &&
                (since >= done_delay - 1);

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // per-cycle scoreboard compare
  int   ov_seen = 0;
  bit   prev_stall = 0;
  bit   prev_req = 0;
  logic [7:0] prev_dat = 0;
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (mem_wr_en) begin
        chk("wr_sel", {31'd0, mem_sel}, 1);
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexp_wr actual=%0h:%0h required=none",
                   mem_addr, mem_wr_dat);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
          chk("wr_dat", {24'd0, mem_wr_dat}, {24'd0, e.d});
        end
      end
      if (out_valid) begin
        ov_seen++;
        chk("out_sel", {31'd0, mem_sel}, 1);
        if (prev_stall)
          chk("out_stable", {24'd0, out_dat}, {24'd0, prev_dat});
        if (out_ready) begin
          if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexp_out actual=%0h required=none",
                     out_dat);
          end else begin
            logic [7:0] r;
            r = rq.pop_front();
            chk("out_dat", {24'd0, out_dat}, {24'd0, r});
          end
        end
      end
      if (req) chk("req_single", {31'd0, prev_req}, 0);
      if (in_ready || req || out_valid)
        chk("busy_active", {31'd0, busy}, 1);
      prev_stall = out_valid && !out_ready;
      prev_dat = out_dat;
      prev_req = req;
    end else begin
      prev_stall = 0;
      prev_req = 0;
    end
  end

  task automatic run_seq(input int dly, input logic [7:0] dbase,
                         input bit stall, input bit inject,
                         input bit abort, input int exp_cnt,
                         input bit exp_err);
    int n;
    int stall_left;
    int ov_base;
    done_delay = dly;
    ov_base = ov_seen;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_dat = 8'(dbase + k);
      wq.push_back('{a: 8'(k), d: 8'(dbase + k)});
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("load_ready", {31'd0, in_ready}, 1);
      @(negedge clk);
    end
    in_valid = 0;
    n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, req}, 1);
    if (inject) begin
      @(negedge clk);
      chk("run_in_ready", {31'd0, in_ready}, 0);
      start = 1;
      in_valid = 1;
      in_dat = 8'hEE;
      @(negedge clk);
      start = 0;
      in_valid = 0;
    end
    if (abort) begin
      repeat (3) @(negedge clk);
      reset = 1;
      #1;
      chk("abort_core_rst", {31'd0, core_rst}, 1);
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_req", {31'd0, req}, 0);
      chk("abort_core_rst2", {31'd0, core_rst}, 1);
      chk("abort_out_valid", {31'd0, out_valid}, 0);
      chk("abort_cnt", {16'd0, cycle_count}, 0);
      reset = 0;
      @(negedge clk);
      chk("abort_core_rst_lo", {31'd0, core_rst}, 0);
      chk("abort_idle_busy", {31'd0, busy}, 0);
      chk("abort_wq", wq.size(), 0);
    end else begin
      if (!exp_err)
        for (int i = 0; i < 4; i++)
          rq.push_back(8'(8'd64 + i) ^ 8'h5A);
      stall_left = stall ? 10 : 0;
      n = 0;
      while (busy && n < 20000) begin
        if (out_valid && stall_left > 0) begin
          out_ready = 0;
          chk("stall_addr", {24'd0, mem_addr}, 32'h40);
          chk("stall_dat", {24'd0, out_dat}, 32'h1A);
          stall_left--;
        end else begin
          out_ready = 1;
        end
        @(negedge clk);
        n++;
      end
      out_ready = 1;
      chk("fin_busy", {31'd0, busy}, 0);
      chk("fin_cnt", {16'd0, cycle_count}, exp_cnt);
      chk("fin_err", {31'd0, timeout_err}, {31'd0, exp_err});
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_cnt", {16'd0, cycle_count}, exp_cnt);
      chk("idle_err", {31'd0, timeout_err}, {31'd0, exp_err});
      chk("wq_empty", wq.size(), 0);
      chk("rq_empty", rq.size(), 0);
      if (exp_err) chk("no_out", ov_seen - ov_base, 0);
    end
  endtask

  initial begin
    reset = 1;
    start = 0;
    in_valid = 0;
    in_dat = 0;
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
    chk("rst_sel", {31'd0, mem_sel}, 0);
    chk("rst_cnt", {16'd0, cycle_count}, 0);
    chk("rst_err", {31'd0, timeout_err}, 0);
    chk("rst_core_rst", {31'd0, core_rst}, 1);
    reset = 0;
    @(negedge clk);
    chk("idle_core_rst", {31'd0, core_rst}, 0);
    chk("idle_busy0", {31'd0, busy}, 0);

    run_seq(37, 8'h01, 0, 0, 0, 37, 0);
    run_seq(12, 8'h30, 1, 0, 0, 12, 0);
    run_seq(0, 8'h10, 0, 0, 0, 5000, 1);
    run_seq(20, 8'h50, 0, 0, 1, 0, 0);
    run_seq(20, 8'h60, 0, 0, 0, 20, 0);
    run_seq(5001, 8'h70, 0, 0, 0, 5000, 0);
    run_seq(15, 8'h80, 0, 1, 0, 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 Parameter LOAD_BASE, 8'd0: first data-memory address written during preload.
REQ-002 Parameter LOAD_LEN, 8: number of bytes preloaded (1..256).
REQ-003 Parameter RES_BASE, 8'd64: first data-memory address read back after run.
REQ-004 Parameter RES_LEN, 4: number of result bytes drained (1..256).
REQ-005 Parameter TIMEOUT, 16'd5000: max RUN cycles before abort.
REQ-006 clk  input  1  sole clock, all state updates on posedge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 start  input  1  host request to begin one load/run/drain sequence.
REQ-009 in_valid / in_ready / in_dat  input / output / 8  preload byte stream.
REQ-010 out_valid / out_ready / out_dat  output / input / 8  result byte stream.
REQ-011 core_rst  output  1  reset to processor core.
REQ-012 req  output  1  run request to processor core.
REQ-013 done  input  1  processor done level, high while core PC == 128.
REQ-014 mem_sel  output  1  1 = sequencer owns data-memory port, 0 = core owns it.
REQ-015 mem_wr_en / mem_addr / mem_wr_dat  output / 8 / 8  data-memory write port.
REQ-016 mem_rd_dat  input  8  data-memory read data; combinational, valid in the same cycle as mem_addr.
REQ-017 busy, timeout_err  output  1 each; cycle_count  output  16.

Function
REQ-018 FSM states: IDLE, LOAD, CRST, REQ, RUN, DRAIN, FIN.
REQ-019 IDLE: start=1 -> LOAD, clear idx, cycle_count, and timeout_err; start in any other state is ignored.
REQ-020 LOAD: in_ready=1, mem_sel=1; on in_valid&in_ready, write in_dat to LOAD_BASE+idx (8-bit wrap) and increment idx; after byte LOAD_LEN-1 -> CRST.
REQ-021 in_ready=0 in every state other than LOAD.
REQ-022 CRST: core_rst=1 for exactly 2 cycles, then REQ; this guarantees done is low before req.
REQ-023 REQ: req=1 for exactly 1 cycle, then RUN; req=0 in all other states.
REQ-024 RUN: mem_sel=0; cycle_count increments each cycle, saturating at 16'hFFFF.
REQ-025 RUN exit on done sampled high: -> DRAIN, with idx cleared and cycle_count frozen.
REQ-026 RUN exit when cycle_count == TIMEOUT without done: set timeout_err (sticky until next start) and go to FIN, skipping DRAIN.
REQ-027 If done and timeout occur in the same cycle, done wins: no error, go to DRAIN.
REQ-028 DRAIN: mem_sel=1, mem_addr=RES_BASE+idx (8-bit wrap), out_valid=1, out_dat=mem_rd_dat.
REQ-029 DRAIN: idx advances only on out_valid&out_ready; out_dat stays stable while out_valid&!out_ready.
REQ-030 DRAIN: after byte RES_LEN-1 is accepted -> FIN.
REQ-031 FIN: one cycle, busy=0, then IDLE; cycle_count and timeout_err hold until next start.
REQ-032 busy=1 in every state except IDLE and FIN.
REQ-033 mem_wr_en is asserted only during LOAD handshake cycles.

Reset
REQ-034 reset=1 forces IDLE from any state, including mid-LOAD, mid-RUN, and mid-DRAIN.
REQ-035 Reset values: idx=0, cycle_count=0, timeout_err=0, busy=0, req=0, in_ready=0, out_valid=0, mem_wr_en=0, mem_sel=0.
REQ-036 core_rst=1 while reset=1; in IDLE core_rst=0.

Structure
REQ-037 A shared package holds the state enum and the default parameter constants (LOAD_LEN, RES_LEN, TIMEOUT, RES_BASE).
REQ-038 One sub-module, seq_counter (16-bit counter with load-zero, enable, and saturate), serves cycle_count; idx is a local 9-bit counter.

Verification
REQ-039 Load bytes 1..8, core model raises done 37 cycles after req -> mem writes at addr 0..7 with data 1..8; cycle_count=37; 4 result bytes from addr 64..67 on out_dat; timeout_err=0.
REQ-040 Core never raises done -> timeout_err=1 after 5000 RUN cycles, no out_valid, FIN then IDLE.
REQ-041 out_ready held low 10 cycles in DRAIN -> out_dat constant, idx unchanged, no byte lost or repeated.
REQ-042 reset pulsed in the 3rd RUN cycle -> next cycle IDLE, req=0, busy=0, core_rst=1 during reset; new start completes normally.
REQ-043 done rises on the same cycle cycle_count==TIMEOUT -> DRAIN entered, timeout_err=0.
REQ-044 start pulsed while busy and in_valid asserted in RUN -> both ignored, no extra writes.
